// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: default 800x600@60 constants and a
// per-axis timing record for describing additional video modes.
package vga_pkg;

    // One axis (horizontal or vertical) of a video mode, in pixels or lines.
    typedef struct packed {
        logic [15:0] active;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
    } vga_timing_t;

    // 800x600@60 (40 MHz pixel clock), positive sync polarity.
    localparam int unsigned VGA_H_ACTIVE_DEF = 800;
    localparam int unsigned VGA_H_FP_DEF     = 40;
    localparam int unsigned VGA_H_SYNC_DEF   = 128;
    localparam int unsigned VGA_H_BP_DEF     = 88;
    localparam int unsigned VGA_V_ACTIVE_DEF = 600;
    localparam int unsigned VGA_V_FP_DEF     = 1;
    localparam int unsigned VGA_V_SYNC_DEF   = 4;
    localparam int unsigned VGA_V_BP_DEF     = 23;
    localparam bit          VGA_H_POL_DEF    = 1'b1;
    localparam bit          VGA_V_POL_DEF    = 1'b1;

    localparam vga_timing_t VGA_800X600_H = '{
        active: 16'd800, fp: 16'd40, sync: 16'd128, bp: 16'd88
    };
    localparam vga_timing_t VGA_800X600_V = '{
        active: 16'd600, fp: 16'd1, sync: 16'd4, bp: 16'd23
    };

    // Total period of one axis of a mode.
    function automatic int unsigned vga_axis_total(input vga_timing_t t);
        return int'(t.active) + int'(t.fp) + int'(t.sync) + int'(t.bp);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: a wrapping position counter plus the active-region and
// sync-region decodes of its current count. Decodes are combinational so
// the caller decides where to register them.
module vga_axis_counter #(
    parameter int unsigned W          = 11,
    parameter int unsigned total      = 1056,
    parameter int unsigned sync_start = 840,
    parameter int unsigned sync_len   = 128,
    parameter int unsigned active     = 800,
    parameter bit          polarity   = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         in_active,
    output logic         sync
);

    // With active >= 1 and sync >= 1, every constant below is at most
    // total-1 and so fits W bits exactly. The sync test is written as an
    // offset compare so the end-of-sync bound (which may equal total when
    // the back porch is zero) is never formed in W bits.
    localparam logic [W-1:0] LAST       = W'(total - 1);
    localparam logic [W-1:0] SYNC_START = W'(sync_start);
    localparam logic [W-1:0] SYNC_LEN   = W'(sync_len);
    localparam logic [W-1:0] ACTIVE_END = W'(active);

    if (total > (1 << W)) begin : g_width_check
        $error("vga_axis_counter: total does not fit in W bits");
    end

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: advance on inc, wrapping from the last position to zero.
    always_comb begin
        wrap    = inc && (count_q == LAST);
        count_d = count_q;
        if (inc) begin
            count_d = wrap ? '0 : count_q + 1'b1;
        end
    end

    // Position register; reset parks on the last position so the first
    // advance after reset lands on zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= LAST;
        end else begin
            count_q <= count_d;
        end
    end

    // Region decodes of the current position.
    always_comb begin
        in_active = (count_q < ACTIVE_END);
        sync      = ((count_q >= SYNC_START) && ((count_q - SYNC_START) < SYNC_LEN))
                    ? polarity : ~polarity;
    end

    assign count = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. Position outputs come straight from the
// counters; RGB/HSYNC/VSYNC/DE are a one-ce-cycle registered view of the
// same position, so colour presented for (pix_x, pix_y) appears on RGB
// exactly one pixel later, aligned with its syncs and DE.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE_DEF,
    parameter int unsigned H_FP     = VGA_H_FP_DEF,
    parameter int unsigned H_SYNC   = VGA_H_SYNC_DEF,
    parameter int unsigned H_BP     = VGA_H_BP_DEF,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE_DEF,
    parameter int unsigned V_FP     = VGA_V_FP_DEF,
    parameter int unsigned V_SYNC   = VGA_V_SYNC_DEF,
    parameter int unsigned V_BP     = VGA_V_BP_DEF,
    parameter bit          H_POL    = VGA_H_POL_DEF,
    parameter bit          V_POL    = VGA_V_POL_DEF,
    parameter int unsigned COLOR_W  = 3,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned XW      = $clog2(H_TOTAL),
    localparam int unsigned YW      = $clog2(V_TOTAL)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ce,
    input  logic [COLOR_W-1:0] color,
    output logic [XW-1:0]      pix_x,
    output logic [YW-1:0]      pix_y,
    output logic               active,
    output logic               frame_start,
    output logic               line_start,
    output logic [COLOR_W-1:0] RGB,
    output logic               HSYNC,
    output logic               VSYNC,
    output logic               DE
);

    // A zero-width sync or visible region has no meaningful timing.
    if (H_SYNC == 0 || V_SYNC == 0 || H_ACTIVE == 0 || V_ACTIVE == 0) begin : g_param_check
        $error("vga_timing_gen: SYNC and ACTIVE parameters must be >= 1");
    end

    logic [XW-1:0] h_count;
    logic [YW-1:0] v_count;
    logic          h_wrap;
    logic          h_active;
    logic          h_sync;
    logic          v_active;
    logic          v_sync;
    logic          frame_wrap_unused;

    vga_axis_counter #(
        .W          (XW),
        .total      (H_TOTAL),
        .sync_start (H_ACTIVE + H_FP),
        .sync_len   (H_SYNC),
        .active     (H_ACTIVE),
        .polarity   (H_POL)
    ) u_h_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (ce),
        .count     (h_count),
        .wrap      (h_wrap),
        .in_active (h_active),
        .sync      (h_sync)
    );

    // The vertical axis advances once per line, on the horizontal wrap, so
    // its sync decode is inherently line-aligned.
    vga_axis_counter #(
        .W          (YW),
        .total      (V_TOTAL),
        .sync_start (V_ACTIVE + V_FP),
        .sync_len   (V_SYNC),
        .active     (V_ACTIVE),
        .polarity   (V_POL)
    ) u_v_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (h_wrap),
        .count     (v_count),
        .wrap      (frame_wrap_unused),
        .in_active (v_active),
        .sync      (v_sync)
    );

    logic [COLOR_W-1:0] rgb_q, rgb_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               de_q, de_d;

    // Position-derived outputs, zero latency from the counters.
    always_comb begin
        pix_x       = h_count;
        pix_y       = v_count;
        active      = h_active && v_active;
        line_start  = (h_count == '0);
        frame_start = (h_count == '0) && (v_count == '0);
    end

    // Next values of the pixel pipeline stage; everything holds when ce=0.
    always_comb begin
        rgb_d   = rgb_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        de_d    = de_q;
        if (ce) begin
            rgb_d   = (h_active && v_active) ? color : '0;
            hsync_d = h_sync;
            vsync_d = v_sync;
            de_d    = h_active && v_active;
        end
    end

    // Pixel pipeline registers; reset drives blank video and idle syncs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q   <= '0;
            hsync_q <= ~H_POL;
            vsync_q <= ~V_POL;
            de_q    <= 1'b0;
        end else begin
            rgb_q   <= rgb_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
        end
    end

    assign RGB   = rgb_q;
    assign HSYNC = hsync_q;
    assign VSYNC = vsync_q;
    assign DE    = de_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small-geometry instances (positive sync
// polarity, and negative polarity with zero front porches) driven by the
// same stimulus and checked cycle by cycle against a reference raster.
module tb_vga_timing_gen;

    // Instance A: positive polarity.
    localparam int A_HA = 8, A_HFP = 2, A_HS = 3, A_HB = 1;
    localparam int A_VA = 4, A_VFP = 1, A_VS = 2, A_VB = 1;
    localparam int A_HT = A_HA + A_HFP + A_HS + A_HB;   // 14
    localparam int A_VT = A_VA + A_VFP + A_VS + A_VB;   // 8
    // Instance B: negative polarity, zero front porches.
    localparam int B_HA = 8, B_HFP = 0, B_HS = 3, B_HB = 1;
    localparam int B_VA = 4, B_VFP = 0, B_VS = 2, B_VB = 1;
    localparam int B_HT = B_HA + B_HFP + B_HS + B_HB;   // 12
    localparam int B_VT = B_VA + B_VFP + B_VS + B_VB;   // 7

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ce = 1'b0;
    logic [2:0] color = 3'b000;

    logic [3:0] a_x, b_x;
    logic [2:0] a_y, b_y;
    logic       a_active, a_fs, a_ls, a_hs, a_vs, a_de;
    logic       b_active, b_fs, b_ls, b_hs, b_vs, b_de;
    logic [2:0] a_rgb, b_rgb;

    vga_timing_gen #(
        .H_ACTIVE(A_HA), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HB),
        .V_ACTIVE(A_VA), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VB),
        .H_POL(1'b1), .V_POL(1'b1), .COLOR_W(3)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .ce(ce), .color(color),
        .pix_x(a_x), .pix_y(a_y), .active(a_active),
        .frame_start(a_fs), .line_start(a_ls),
        .RGB(a_rgb), .HSYNC(a_hs), .VSYNC(a_vs), .DE(a_de)
    );

    vga_timing_gen #(
        .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HB),
        .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VB),
        .H_POL(1'b0), .V_POL(1'b0), .COLOR_W(3)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .ce(ce), .color(color),
        .pix_x(b_x), .pix_y(b_y), .active(b_active),
        .frame_start(b_fs), .line_start(b_ls),
        .RGB(b_rgb), .HSYNC(b_hs), .VSYNC(b_vs), .DE(b_de)
    );

    // Clock
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scoreboard of registered outputs: {A rgb,hs,vs,de, B rgb,hs,vs,de}
    logic [11:0] exp_q[$];
    logic [11:0] last_reg;
    localparam logic [11:0] RESET_REG = {3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0};

    // Reference positions
    int ah, av, bh, bv;
    // Frame period and visible-run tracking (instance A)
    int  ce_count;
    bit  fs_seen;
    int  run;
    bit  track_runs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Registered outputs expected one ce-cycle after position (h,v).
    function automatic logic [5:0] reg_model(input int h, input int v, input logic [2:0] col,
                                             input int ha, input int hfp, input int hs,
                                             input int va, input int vfp, input int vs,
                                             input bit hp, input bit vp);
        bit act, hin, vin;
        act = (h < ha) && (v < va);
        hin = (h >= ha + hfp) && (h < ha + hfp + hs);
        vin = (v >= va + vfp) && (v < va + vfp + vs);
        return {act ? col : 3'b000, hin ? hp : !hp, vin ? vp : !vp, act};
    endfunction

    task automatic model_reset();
        ah = A_HT - 1; av = A_VT - 1;
        bh = B_HT - 1; bv = B_VT - 1;
        last_reg = RESET_REG;
        fs_seen = 1'b0;
        ce_count = 0;
        run = 0;
        exp_q.delete();
    endtask

    task automatic check_pos();
        check("a_pix_x", 32'(a_x), 32'(ah));
        check("a_pix_y", 32'(a_y), 32'(av));
        check("a_active", 32'(a_active), 32'((ah < A_HA) && (av < A_VA)));
        check("a_line_start", 32'(a_ls), 32'(ah == 0));
        check("a_frame_start", 32'(a_fs), 32'((ah == 0) && (av == 0)));
        check("b_pix_x", 32'(b_x), 32'(bh));
        check("b_pix_y", 32'(b_y), 32'(bv));
        check("b_active", 32'(b_active), 32'((bh < B_HA) && (bv < B_VA)));
        check("b_line_start", 32'(b_ls), 32'(bh == 0));
        check("b_frame_start", 32'(b_fs), 32'((bh == 0) && (bv == 0)));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_a_x"}, 32'(a_x), 32'(A_HT - 1));
        check({tag, "_a_y"}, 32'(a_y), 32'(A_VT - 1));
        check({tag, "_b_x"}, 32'(b_x), 32'(B_HT - 1));
        check({tag, "_b_y"}, 32'(b_y), 32'(B_VT - 1));
        check({tag, "_regs"}, 32'({a_rgb, a_hs, a_vs, a_de, b_rgb, b_hs, b_vs, b_de}),
              32'(RESET_REG));
    endtask

    // Driver: one clock with the given ce/color; called at a negedge.
    task automatic step(input bit ce_v, input logic [2:0] col_v);
        logic [11:0] e;
        ce = ce_v;
        color = col_v;
        if (ce_v) begin
            e = {reg_model(ah, av, col_v, A_HA, A_HFP, A_HS, A_VA, A_VFP, A_VS, 1'b1, 1'b1),
                 reg_model(bh, bv, col_v, B_HA, B_HFP, B_HS, B_VA, B_VFP, B_VS, 1'b0, 1'b0)};
        end else begin
            e = last_reg;
        end
        last_reg = e;
        exp_q.push_back(e);
        @(posedge clk);
        if (ce_v) begin
            if (ah == A_HT - 1) begin ah = 0; av = (av == A_VT - 1) ? 0 : av + 1; end
            else ah++;
            if (bh == B_HT - 1) begin bh = 0; bv = (bv == B_VT - 1) ? 0 : bv + 1; end
            else bh++;
        end
        @(negedge clk);
        check_pos();
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("regs", 32'({a_rgb, a_hs, a_vs, a_de, b_rgb, b_hs, b_vs, b_de}), 32'(e));
        end
        if (ce_v) begin
            ce_count++;
            if (a_fs) begin
                if (fs_seen) check("frame_period", 32'(ce_count), 32'(A_HT * A_VT));
                fs_seen = 1'b1;
                ce_count = 0;
            end
            if (track_runs) begin
                if (a_rgb == 3'b101) run++;
                else if (run != 0) begin
                    check("rgb_run", 32'(run), 32'(A_HA));
                    run = 0;
                end
            end
        end
    endtask

    initial begin
        // Reset
        rst_n = 1'b0;
        ce = 1'b0;
        color = 3'b101;
        track_runs = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        ce = 1'b1;
        @(negedge clk);
        check_reset_state("reset_ce");
        rst_n = 1'b1;

        // First ce cycle after release lands on (0,0)
        step(1'b1, 3'b101);
        check("first_frame_start", 32'(a_fs), 32'd1);

        // Two full frames with ce held high and constant colour
        repeat (2 * A_HT * A_VT + 4) step(1'b1, 3'b101);

        // ce toggling 1,0: positions and registered outputs hold on ce=0
        for (int i = 0; i < 4 * A_HT * 2; i++) step((i % 2) == 0, 3'b101);

        // Advance to (4,2) on instance A, then reset asynchronously mid-frame
        for (int i = 0; i < A_HT * A_VT && !(ah == 4 && av == 2); i++) step(1'b1, 3'b101);
        check("reached_mid_frame", 32'(ah * 100 + av), 32'(402));
        #2 rst_n = 1'b0;
        #1 check_reset_state("async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 3'b110);
        check("restart_frame_start", 32'(a_fs), 32'd1);

        // Random colours over more than one frame
        track_runs = 1'b0;
        repeat (A_HT * A_VT + 20) step(1'b1, 3'($urandom_range(0, 7)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, 800, visible pixels per line.
REQ-002 Parameter H_FP, 40, horizontal front porch, in pixels.
REQ-003 Parameter H_SYNC, 128, horizontal sync width, in pixels.
REQ-004 Parameter H_BP, 88, horizontal back porch, in pixels.
REQ-005 Parameter V_ACTIVE, 600, visible lines per frame.
REQ-006 Parameter V_FP, 1, vertical front porch, in lines.
REQ-007 Parameter V_SYNC, 4, vertical sync width, in lines.
REQ-008 Parameter V_BP, 23, vertical back porch, in lines.
REQ-009 Parameter H_POL, 1, HSYNC active level.
REQ-010 Parameter V_POL, 1, VSYNC active level.
REQ-011 Parameter COLOR_W, 3, colour bus width.
REQ-012 Derived quantities: H_TOTAL = sum of the four H_* parameters; V_TOTAL = sum of the four V_* parameters; XW = $clog2(H_TOTAL); YW = $clog2(V_TOTAL).
REQ-013 Port list (name, direction, width, meaning):
- clk, in, 1: pixel-domain clock.
- rst_n, in, 1: asynchronous active-low reset.
- ce, in, 1: pixel advance enable.
- color, in, COLOR_W: colour for the current (pix_x, pix_y).
- pix_x, out, XW: current horizontal count.
- pix_y, out, YW: current vertical count.
- active, out, 1: current position is visible.
- frame_start, out, 1: one-pixel pulse at (0,0).
- line_start, out, 1: one-pixel pulse at pix_x == 0.
- RGB, out, COLOR_W: colour output.
- HSYNC, out, 1: horizontal sync.
- VSYNC, out, 1: vertical sync.
- DE, out, 1: registered data enable.

Function
REQ-014 The h counter SHALL increment by 1 on each clk edge with ce=1, and wrap from H_TOTAL-1 to 0.
REQ-015 The v counter SHALL increment only when h wraps, and wrap from V_TOTAL-1 to 0 when h and v wrap together.
REQ-016 With ce=0, all counters and all registered outputs SHALL hold their values.
REQ-017 pix_x, pix_y, active, line_start and frame_start SHALL be driven directly from the counter registers, with no added latency.
REQ-018 active SHALL be 1 iff h < H_ACTIVE and v < V_ACTIVE.
REQ-019 line_start SHALL be 1 iff h == 0; frame_start SHALL be 1 iff h == 0 and v == 0.
REQ-020 RGB, HSYNC, VSYNC and DE SHALL be registered one ce-cycle after the position they describe, giving a fixed latency of 1 from color to RGB.
REQ-021 RGB SHALL be color when active, and all zeros otherwise.
REQ-022 HSYNC SHALL equal H_POL for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, and !H_POL otherwise.
REQ-023 VSYNC SHALL equal V_POL for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, and !V_POL otherwise.
REQ-024 VSYNC SHALL change only on the cycle where h wraps to 0, i.e. it is line-aligned.
REQ-025 Each SYNC parameter and each ACTIVE parameter SHALL be >= 1; a violation SHALL raise an elaboration-time error.
REQ-026 Porch parameters MAY be 0, and the boundary arithmetic SHALL remain correct when they are.
REQ-027 All comparisons SHALL use XW/YW-wide unsigned constants with no truncation.

Reset
REQ-028 While rst_n = 0, h SHALL be H_TOTAL-1 and v SHALL be V_TOTAL-1, so the first ce cycle after release lands on (0,0) and frame_start asserts.
REQ-029 During reset: RGB = 0, DE = 0, HSYNC = !H_POL, VSYNC = !V_POL.
REQ-030 Reset asserted mid-frame SHALL take effect immediately and asynchronously, with no partial-line completion.

Structure
REQ-031 Package vga_pkg SHALL hold the default 800x600@60 timing constants and a vga_timing_t struct (active, fp, sync, bp) for the team's future modes.
REQ-032 One sub-module, vga_axis_counter, SHALL be instantiated twice (H and V):
- parameters: total, sync_start, sync_len, active, polarity;
- inputs: clk, rst_n, inc;
- outputs: count, wrap, in_active, sync.

Verification
REQ-033 Reset release, ce=1 constantly -> frame_start high on the first cycle with pix_x=0, pix_y=0; the next frame_start arrives exactly 1056*628 = 663168 cycles later.
REQ-034 color=3'b101 held -> RGB=3'b101 for exactly 800 consecutive cycles per visible line, starting one cycle after line_start; RGB=0 elsewhere.
REQ-035 Default timing -> HSYNC high for 128 cycles, entered one cycle after pix_x=840; VSYNC high for exactly 4*1056 cycles, starting one cycle after the position (0,601).
REQ-036 Toggle ce 1,0 alternately -> every period doubles, and outputs hold during ce=0 cycles.
REQ-037 Assert rst_n=0 at position (400,300) -> RGB=0, HSYNC=0, VSYNC=0 and DE=0 immediately; after release, frame restarts at (0,0).
REQ-038 Rebuild with H_POL=0, V_POL=0 and H_FP=0 -> HSYNC is low for 128 cycles starting one cycle after pix_x=800, and idles high otherwise.
